// File: rtl/wrq_if.sv
// Purpose : bundle of the arbiter's queue-status inputs and grant outputs.
// Ports   : data_queue_valid, free_space, write_done  (toward the arbiter)
//           write_queue, app_id, busy, write_timeout  (from the arbiter)
// Modports: slave  - the wrq arbiter itself
//           master - the surrounding system / queues / write engine
interface wrq_if #(
  parameter int TOTAL_APPS     = 8,
  parameter int APP_ID_WIDTH   = 3,
  parameter int FIFO_ADD_WIDTH = 10
);
  logic [TOTAL_APPS-1:0]     data_queue_valid;
  logic [FIFO_ADD_WIDTH-1:0] free_space;
  logic                      write_done;
  logic                      write_queue;
  logic [APP_ID_WIDTH-1:0]   app_id;
  logic                      busy;
  logic                      write_timeout;

  modport slave (
    input  data_queue_valid, free_space, write_done,
    output write_queue, app_id, busy, write_timeout
  );

  modport master (
    output data_queue_valid, free_space, write_done,
    input  write_queue, app_id, busy, write_timeout
  );
endinterface

// File: rtl/wrq.sv
// Purpose : write-request queue arbiter. Round-robin grant among non-empty
//           application TX queues, gated by free space in the shared outgoing
//           FIFO; a single grant is outstanding until the write engine reports
//           done or the wait times out.
// Ports   : clk  - rising-edge clock
//           rst  - asynchronous active-high reset
//           bus  - wrq_if.slave (queue status in, grant/status out)
//
// state | meaning
// IDLE  | pick next eligible app (round robin from last winner)
// ISSUE | write_queue pulse for the registered app_id
// WAIT  | wait for write_done, abort after TIMEOUT cycles
// HOLD  | one settle cycle before the next decision
module wrq #(
  parameter int TOTAL_APPS     = 8,
  parameter int APP_ID_WIDTH   = 3,
  parameter int FIFO_ADD_WIDTH = 10,
  parameter int BURST_LEN      = 16,
  parameter int TIMEOUT        = 1024
) (
  input  logic  clk,
  input  logic  rst,
  wrq_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam logic [FIFO_ADD_WIDTH-1:0] BURST_LEN_W = FIFO_ADD_WIDTH'(BURST_LEN);
  localparam logic [15:0]               TIMER_LAST  = 16'(TIMEOUT - 1);
  localparam logic [APP_ID_WIDTH-1:0]   PTR_RESET   = APP_ID_WIDTH'(TOTAL_APPS - 1);

  logic [1:0]              r_state;
  logic [APP_ID_WIDTH-1:0] r_app_id;
  logic [APP_ID_WIDTH-1:0] r_ptr;
  logic [15:0]             r_timer;

  logic [TOTAL_APPS-1:0]   w_eligible;
  logic                    w_any;
  logic [APP_ID_WIDTH-1:0] w_winner;
  logic                    w_timer_last;

  assign w_eligible   = bus.data_queue_valid & {TOTAL_APPS{bus.free_space >= BURST_LEN_W}};
  assign w_timer_last = (r_timer == TIMER_LAST);

  // Search starts one past the last winner and wraps modulo TOTAL_APPS so
  // that non-power-of-two app counts never produce an out-of-range id.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    for (int i = 1; i <= TOTAL_APPS; i++) begin
      if (!w_any && w_eligible[(int'(r_ptr) + i) % TOTAL_APPS]) begin
        w_any    = 1'b1;
        w_winner = APP_ID_WIDTH'((int'(r_ptr) + i) % TOTAL_APPS);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_app_id <= '0;
      r_ptr    <= PTR_RESET;
      r_timer  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_app_id <= w_winner;
            r_ptr    <= w_winner;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_timer <= '0;
          // An engine that finishes in the issue cycle skips WAIT entirely.
          r_state <= bus.write_done ? S_HOLD : S_WAIT;
        end
        S_WAIT: begin
          if (bus.write_done || w_timer_last) begin
            r_state <= S_HOLD;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.write_queue   = (r_state == S_ISSUE);
  assign bus.busy          = (r_state != S_IDLE);
  assign bus.app_id        = r_app_id;
  // done wins over a coincident timeout
  assign bus.write_timeout = (r_state == S_WAIT) && w_timer_last && !bus.write_done;

endmodule

// File: tb/tb_wrq.sv
module tb_wrq;
  localparam int APPS = 8;
  localparam int TMO  = 8;

  logic clk;
  logic rst;

  wrq_if #(.TOTAL_APPS(APPS), .APP_ID_WIDTH(3), .FIFO_ADD_WIDTH(10)) bus ();

  wrq #(
    .TOTAL_APPS(APPS), .APP_ID_WIDTH(3), .FIFO_ADD_WIDTH(10),
    .BURST_LEN(16), .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // stimulus state
  logic [7:0] t_valid = '0;
  logic [9:0] t_free  = '0;
  logic       t_rst   = 1'b1;
  int         done_delay = -1;   // cycles after write_queue; -1 = never
  bit         rand_mode  = 0;
  int         done_cnt   = -1;

  // reference model: cycle numbers of issue / return to idle
  int  cyc     = 0;
  int  m_ptr   = APPS - 1;
  int  m_id    = 0;
  int  m_issue = -10;
  int  m_free  = 0;
  bit  m_wait  = 0;

  // observation helpers for directed checks
  int  wq_seen   = 0;
  int  last_wq_c = -100;
  int  wq_gap    = 0;
  int  ids[$];

  task automatic drive();
    int r;
    rst = t_rst;
    bus.data_queue_valid = t_valid;
    bus.free_space       = t_free;
    if (bus.write_queue && !t_rst) begin
      if (rand_mode) begin
        r = int'($urandom_range(0, 12));
        done_cnt = (r > 10) ? -1 : r;
      end else begin
        done_cnt = done_delay;
      end
    end
    bus.write_done = (done_cnt == 0);
    if (rand_mode && done_cnt < 0 && $urandom_range(0, 15) == 0) bus.write_done = 1'b1;
    if (done_cnt >= 0) done_cnt--;
  endtask

  task automatic model_check();
    bit exp_wq, exp_busy, exp_to;
    if (rst) begin
      chk("rst_wq",   32'(bus.write_queue),   0);
      chk("rst_busy", 32'(bus.busy),          0);
      chk("rst_to",   32'(bus.write_timeout), 0);
      chk("rst_id",   32'(bus.app_id),        0);
      m_ptr = APPS - 1; m_id = 0; m_wait = 0; m_issue = -10; m_free = cyc + 1;
      return;
    end
    exp_wq   = (cyc == m_issue);
    exp_busy = m_wait || (cyc < m_free);
    exp_to   = m_wait && (cyc > m_issue) && ((cyc - m_issue) == TMO) && !bus.write_done;
    chk("write_queue",   32'(bus.write_queue),   32'(exp_wq));
    chk("busy",          32'(bus.busy),          32'(exp_busy));
    chk("write_timeout", 32'(bus.write_timeout), 32'(exp_to));
    chk("app_id",        32'(bus.app_id),        32'(m_id));
    if (bus.write_queue) begin
      wq_seen++;
      wq_gap = cyc - last_wq_c;
      last_wq_c = cyc;
      ids.push_back(int'(bus.app_id));
    end
    if (m_wait) begin
      if (bus.write_done || exp_to) begin
        m_wait = 0;
        m_free = cyc + 2;
      end
    end else if (cyc >= m_free && bus.free_space >= 10'd16) begin
      for (int k = 1; k <= APPS; k++) begin
        if (!m_wait && t_valid[(m_ptr + k) % APPS]) begin
          m_id    = (m_ptr + k) % APPS;
          m_ptr   = m_id;
          m_issue = cyc + 1;
          m_wait  = 1;
        end
      end
    end
  endtask

  task automatic step(input int n);
    for (int s = 0; s < n; s++) begin
      @(posedge clk);
      #1;
      drive();
      @(negedge clk);
      model_check();
      cyc++;
    end
  endtask

  initial begin
    int cnt_to;
    rst = 1'b1;
    bus.data_queue_valid = '0;
    bus.free_space = '0;
    bus.write_done = 1'b0;

    // reset, idle with nothing valid
    t_rst = 1; step(3);
    t_rst = 0; step(4);

    // round robin with everything valid, done 2 cycles after each issue
    ids.delete();
    t_valid = 8'hFF; t_free = 10'd64; done_delay = 2;
    step(50);
    chk("rr_count", 32'(ids.size() >= 9), 1);
    for (int i = 0; i < 9 && i < ids.size(); i++) chk("rr_seq", 32'(ids[i]), 32'(i % APPS));

    // reset in the middle of WAIT
    done_delay = -1; t_valid = 8'h08;
    step(5);
    chk("pre_rst_busy", 32'(bus.busy), 1);
    t_rst = 1; step(2);
    t_rst = 0; t_valid = 8'hFF; done_delay = 1;
    ids.delete();
    step(6);
    chk("post_rst_first", 32'(ids.size() > 0 ? ids[0] : 99), 0);

    // skip/wrap: bring ptr to 5, then valid = 0000_0101
    t_valid = 8'h00; step(6);
    t_valid = 8'h20; step(2);
    t_valid = 8'h00; step(8);
    ids.delete();
    t_valid = 8'h05; step(15);
    chk("wrap_n", 32'(ids.size() >= 3), 1);
    if (ids.size() >= 3) begin
      chk("wrap0", 32'(ids[0]), 0);
      chk("wrap1", 32'(ids[1]), 2);
      chk("wrap2", 32'(ids[2]), 0);
    end

    // space gate: 15 blocks, 16 permits
    t_valid = 8'h00; step(8);
    t_valid = 8'h01; t_free = 10'd15;
    wq_seen = 0;
    step(100);
    chk("gate_blocked", 32'(wq_seen), 0);
    t_free = 10'd16; step(1);
    step(1);
    chk("gate_open_wq", 32'(bus.write_queue), 1);
    chk("gate_open_id", 32'(bus.app_id), 0);
    step(8);

    // timeout: no done ever
    t_valid = 8'h00; step(10);
    done_delay = -1; t_valid = 8'h02;
    cnt_to = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (bus.write_timeout) cnt_to++;
    end
    chk("timeout_seen", 32'(cnt_to >= 2), 1);
    // done coincident with the timeout cycle: no pulse
    done_delay = TMO;
    cnt_to = 0;
    step(12);
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (bus.write_timeout) cnt_to++;
    end
    chk("timeout_done_wins", 32'(cnt_to), 0);

    // early done in the issue cycle: 3-cycle grant spacing
    t_valid = 8'h00; step(12);
    done_delay = 0; t_valid = 8'hFF;
    step(12);
    chk("early_gap", 32'(wq_gap), 3);

    // randomized traffic
    rand_mode = 1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) t_valid = 8'($urandom);
      if ($urandom_range(0, 5) == 0)
        t_free = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(13, 19));
      if ($urandom_range(0, 299) == 0) begin
        t_rst = 1; step(1); t_rst = 0;
      end
      step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
